// File: rtl/router_port_arbiter_if.sv
// Handshake bundle between the input-port buffers and the router port arbiter.
// The arbiter uses the slave modport; the requester/downstream side uses master.
interface router_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           out_valid;
    logic [DATA_W-1:0]              out_data;
    logic                           out_last;
    logic                           out_ready;
    logic [IDX_W-1:0]               grant_id;
    logic                           busy;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, grant_id, busy
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant_id, busy
    );
endinterface

// File: rtl/router_port_arbiter.sv
// Round-robin arbiter for one router output link with a single output register stage.
// Define ROUTER_ARB_PKT_LOCK_EN to hold the grant for a whole multi-flit packet.
module router_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    router_port_arbiter_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]   NREQ     = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, PKT} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] winner, acc_idx;
    logic             slot_free, acc;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    assign slot_free = !bus.out_valid | bus.out_ready;

    // Scan from the far end back toward ptr so the nearest valid port wins last.
    always_comb begin
        logic [IDX_W:0] idx;
        winner = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_valid[idx[IDX_W-1:0]]) winner = idx[IDX_W-1:0];
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        owner_n       = owner;
        acc           = 1'b0;
        acc_idx       = winner;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (!rst && slot_free && |bus.req_valid) begin
                    bus.req_ready[winner] = 1'b1;
                    acc                   = 1'b1;
                    if (bus.req_last[winner]) begin
                        ptr_n = next_idx(winner);
                    end else begin
`ifdef ROUTER_ARB_PKT_LOCK_EN
                        state_n = PKT;
                        owner_n = winner;
`else
                        ptr_n = next_idx(winner);
`endif
                    end
                end
            end
            PKT: begin
                acc_idx = owner;
                if (!rst && slot_free && bus.req_valid[owner]) begin
                    bus.req_ready[owner] = 1'b1;
                    acc                  = 1'b1;
                    if (bus.req_last[owner]) begin
                        state_n = IDLE;
                        ptr_n   = next_idx(owner);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.grant_id  <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            bus.busy <= (state_n == PKT);
            if (acc) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.req_data[acc_idx];
                bus.out_last  <= bus.req_last[acc_idx];
                bus.grant_id  <= acc_idx;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_router_port_arbiter.sv
// Randomised bench for router_port_arbiter against a transaction-level reference model.
module tb_router_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ROUTER_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    router_port_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
    router_port_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errs   = 0;
    int checks = 0;

    // Reference model: owner = -1 means no packet lock is held.
    int          m_ptr, m_owner, m_gid;
    bit          m_ov, m_ol, m_busy;
    logic [DW-1:0] m_od;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_owner = -1; m_gid = 0;
        m_ov = 0; m_ol = 0; m_busy = 0; m_od = '0;
    endtask

    function automatic int m_pick();
        bit slot;
        slot = !m_ov || bus.out_ready;
        if (rst || !slot) return -1;
        if (m_owner >= 0) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check_outputs(input logic [N-1:0] er);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_data",  64'(bus.out_data),  64'(m_od));
        chk("out_last",  64'(bus.out_last),  64'(m_ol));
        chk("grant_id",  64'(bus.grant_id),  64'(m_gid));
        chk("busy",      64'(bus.busy),      64'(m_busy));
    endtask

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input logic [N-1:0] v, input logic [N-1:0] l, input bit ordy,
                             input bit use_fixed, input logic [DW-1:0] fixed);
        int a;
        logic [N-1:0] er;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.out_ready = ordy;
        for (int i = 0; i < N; i++) bus.req_data[i] = use_fixed ? fixed : DW'($urandom);
        #4;
        a  = m_pick();
        er = '0;
        if (a >= 0) er[a] = 1'b1;
        check_outputs(er);
        if (a >= 0) begin
            m_ov = 1; m_od = bus.req_data[a]; m_ol = l[a]; m_gid = a;
            if (m_owner < 0) begin
                if (l[a] || !LOCK) m_ptr = (a + 1) % N;
                else begin m_owner = a; m_busy = 1; end
            end else if (l[a]) begin
                m_owner = -1; m_busy = 0; m_ptr = (a + 1) % N;
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int n);
        logic [N-1:0] v, l;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 2) != 0);
                l[i] = ($urandom_range(0, 2) == 0);
            end
            run_cycle(v, l, ($urandom_range(0, 3) != 0), 1'b0, '0);
        end
    endtask

    initial begin
        m_reset();
        bus.req_valid = '1;
        bus.req_last  = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        #2;
        check_outputs('0);
        @(posedge clk);
        #1;
        check_outputs('0);
        rst = 1'b0;

        // First accept after reset goes to port 0, then round-robin 1,2,3,0.
        run_cycle('1, '1, 1'b1, 1'b0, '0);
        chk("first_grant", 64'(bus.grant_id), 64'd0);
        for (int c = 0; c < 5; c++) run_cycle('1, '1, 1'b1, 1'b0, '0);

        // Three-flit packet from port 2 contending with port 1.
        run_cycle(4'b0110, 4'b0000, 1'b1, 1'b0, '0);
        run_cycle(4'b0110, 4'b0000, 1'b1, 1'b0, '0);
        run_cycle(4'b0110, 4'b0100, 1'b1, 1'b0, '0);
        run_cycle(4'b0110, 4'b0110, 1'b1, 1'b0, '0);
        run_cycle(4'b0010, 4'b0010, 1'b1, 1'b0, '0);
        run_cycle(4'b0000, 4'b0000, 1'b1, 1'b0, '0);

        // Backpressure with a known flit held on the output.
        run_cycle(4'b0001, '1, 1'b1, 1'b1, 32'hA5A5A5A5);
        for (int c = 0; c < 5; c++) run_cycle('1, '1, 1'b0, 1'b0, '0);
        chk("bp_hold", 64'(bus.out_data), 64'hA5A5A5A5);
        run_cycle('1, '1, 1'b1, 1'b0, '0);

        // Drive ptr to 3, then only port 0 valid must wrap to port 0.
        run_cycle(4'b0100, '1, 1'b1, 1'b0, '0);
        run_cycle(4'b0001, '1, 1'b1, 1'b0, '0);
        chk("wrap_grant", 64'(bus.grant_id), 64'd0);

        rand_cycles(1500);

        // Drain to idle, open a packet on port 1, then reset asynchronously mid-packet.
        for (int c = 0; c < 3; c++) run_cycle('1, '1, 1'b1, 1'b0, '0);
        run_cycle(4'b0010, 4'b0000, 1'b1, 1'b0, '0);
        #1 rst = 1'b1;
        #1;
        m_reset();
        check_outputs('0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_cycle('1, '0, 1'b1, 1'b0, '0);
        chk("post_rst_grant", 64'(bus.grant_id), 64'd0);

        rand_cycles(500);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
